l2_noc_out_packetizer: RTL and testbench

Sits directly downstream of the L2 core's outgoing request and response channels. Arbitrates one `l2_req_out` or one `l2_rsp_out` message per packet and captures it into a one-entry buffer. Serializes each captured message into NoC flits on a single shared plane: two header flits followed by one data flit per word selected by `word_mask`. Holds every flit stable under NoC backpressure.

---
 rtl/spandex_noc_pkg.sv | 104 ++++++++++
 rtl/l2_noc_out_packetizer_if.sv | 28 ++
 rtl/l2_noc_mask_scan.sv | 21 ++
 rtl/l2_noc_out_packetizer.sv | 169 ++++++++++++++++
 tb/tb_l2_noc_out_packetizer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/spandex_noc_pkg.sv
// Shared NoC flit layout, message types and coherence-message helpers.
package spandex_noc_pkg;

    // Flit layout
    localparam int unsigned NOC_FLIT_W    = 66;
    localparam int unsigned NOC_PAYLOAD_W = 64;
    localparam int unsigned FLIT_HEAD_BIT = 65;
    localparam int unsigned FLIT_TAIL_BIT = 64;

    // HDR0 field offsets within the payload
    localparam int unsigned HDR_MSG_LSB   = 60;
    localparam int unsigned HDR_MSG_W     = 4;
    localparam int unsigned HDR_DST_LSB   = 56;
    localparam int unsigned HDR_SRC_LSB   = 52;
    localparam int unsigned HDR_PLANE_BIT = 51;
    localparam int unsigned HDR_MASK_LSB  = 32;
    localparam int unsigned HDR_MASK_W    = 16;

    // Message geometry
    localparam int unsigned NOC_ID_W       = 4;
    localparam int unsigned COH_MSG_W      = 3;
    localparam int unsigned HPROT_W        = 2;
    localparam int unsigned LINE_ADDR_W    = 28;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_W         = 64;
    localparam int unsigned WORD_IDX_W     = $clog2(WORDS_PER_LINE);

    typedef logic [NOC_ID_W-1:0]                    noc_id_t;
    typedef logic [COH_MSG_W-1:0]                   coh_msg_t;
    typedef logic [HPROT_W-1:0]                     hprot_t;
    typedef logic [LINE_ADDR_W-1:0]                 line_addr_t;
    typedef logic [WORDS_PER_LINE-1:0]              word_mask_t;
    typedef logic [WORD_IDX_W-1:0]                  word_idx_t;
    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0]  line_t;
    typedef logic [NOC_FLIT_W-1:0]                  noc_flit_t;

    // Plane tag carried in HDR0
    typedef logic plane_t;
    localparam plane_t PLANE_REQ = 1'b0;
    localparam plane_t PLANE_RSP = 1'b1;

    // Request coherence messages
    localparam coh_msg_t REQ_S      = 3'd0;
    localparam coh_msg_t REQ_O      = 3'd1;
    localparam coh_msg_t REQ_V      = 3'd2;
    localparam coh_msg_t REQ_WT     = 3'd3;
    localparam coh_msg_t REQ_WB     = 3'd4;
    localparam coh_msg_t REQ_O_DATA = 3'd5;
    localparam coh_msg_t REQ_WTdata = 3'd6;
    localparam coh_msg_t REQ_WTFWD  = 3'd7;

    // Response coherence messages
    localparam coh_msg_t RSP_S       = 3'd0;
    localparam coh_msg_t RSP_O       = 3'd1;
    localparam coh_msg_t RSP_V       = 3'd2;
    localparam coh_msg_t RSP_Odata   = 3'd3;
    localparam coh_msg_t RSP_WB_ACK  = 3'd4;
    localparam coh_msg_t RSP_NACK    = 3'd5;
    localparam coh_msg_t RSP_INV_ACK = 3'd6;
    localparam coh_msg_t RSP_RVK_O   = 3'd7;

    typedef struct packed {
        coh_msg_t   coh_msg;
        hprot_t     hprot;
        line_addr_t addr;
        line_t      line;
        word_mask_t word_mask;
    } l2_req_out_t;

    typedef struct packed {
        coh_msg_t   coh_msg;
        noc_id_t    req_id;
        logic       to_req;
        line_addr_t addr;
        line_t      line;
        word_mask_t word_mask;
    } l2_rsp_out_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR0 = 2'd1,
        HDR1 = 2'd2,
        DATA = 2'd3
    } pkt_state_t;

    // Whether a message of this plane/type carries data words after the header.
    function automatic logic msg_has_data(input plane_t plane, input coh_msg_t coh_msg);
        logic has;
        has = 1'b0;
        if (plane == PLANE_RSP) begin
            case (coh_msg)
                RSP_S, RSP_O, RSP_V, RSP_Odata, RSP_WB_ACK: has = 1'b1;
                default:                                    has = 1'b0;
            endcase
        end else begin
            case (coh_msg)
                REQ_WB, REQ_O_DATA, REQ_WTdata: has = 1'b1;
                default:                        has = 1'b0;
            endcase
        end
        return has;
    endfunction

endpackage

// File: rtl/l2_noc_out_packetizer_if.sv
// L2 outgoing request/response channels plus the NoC output plane.
interface l2_noc_out_packetizer_if;
    import spandex_noc_pkg::*;

    logic        l2_req_out_valid;
    logic        l2_req_out_ready;
    l2_req_out_t l2_req_out;

    logic        l2_rsp_out_valid;
    logic        l2_rsp_out_ready;
    l2_rsp_out_t l2_rsp_out;

    logic        noc_out_valid;
    logic        noc_out_ready;
    noc_flit_t   noc_out_data;

    // L2 / NoC side: produces messages, consumes flits
    modport master (
        output l2_req_out_valid, l2_req_out, l2_rsp_out_valid, l2_rsp_out, noc_out_ready,
        input  l2_req_out_ready, l2_rsp_out_ready, noc_out_valid, noc_out_data
    );

    // Packetizer side
    modport slave (
        input  l2_req_out_valid, l2_req_out, l2_rsp_out_valid, l2_rsp_out, noc_out_ready,
        output l2_req_out_ready, l2_rsp_out_ready, noc_out_valid, noc_out_data
    );
endinterface

// File: rtl/l2_noc_mask_scan.sv
// Lowest-set-bit priority encoder over a word mask, with a single-bit-left flag.
module l2_noc_mask_scan
    import spandex_noc_pkg::*;
(
    input  word_mask_t mask,
    output word_idx_t  low_idx_c,
    output logic       last_c
);

    // Scan from the top down so the lowest set bit wins; last means exactly one bit set.
    always_comb begin
        low_idx_c = '0;
        for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx_c = WORD_IDX_W'(i);
            end
        end
        last_c = (mask != '0) && ((mask & (mask - word_mask_t'(1))) == '0);
    end

endmodule

// File: rtl/l2_noc_out_packetizer.sv
// Arbitrates L2 request/response messages and serializes them into NoC flits.
module l2_noc_out_packetizer
    import spandex_noc_pkg::*;
#(
    parameter noc_id_t     SRC_ID     = noc_id_t'(0),
    parameter int unsigned HOME_BITS  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    l2_noc_out_packetizer_if.slave   bus
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    pkt_state_t       state_q,  state_d;
    logic             valid_q,  valid_d;
    noc_flit_t        data_q,   data_d;
    line_addr_t       addr_q,   addr_d;
    line_t            line_q,   line_d;
    word_mask_t       rem_q,    rem_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic       req_rdy_c;
    logic       rsp_rdy_c;
    logic       grant_c;
    logic       starve_sat_c;
    logic       fire_c;
    word_idx_t  scan_idx_c;
    logic       scan_last_c;

    plane_t     sel_plane_c;
    coh_msg_t   sel_msg_c;
    line_addr_t sel_addr_c;
    line_t      sel_line_c;
    word_mask_t sel_mask_c;
    noc_id_t    sel_dst_c;
    noc_flit_t  hdr0_c;

    // Picks the next word to send out of the remaining mask.
    l2_noc_mask_scan u_scan (
        .mask      (rem_q),
        .low_idx_c (scan_idx_c),
        .last_c    (scan_last_c)
    );

    // Arbitration: responses win unless a waiting request has been starved too long.
    always_comb begin
        starve_sat_c = (starve_q == CNT_W'(STARVE_MAX));
        rsp_rdy_c    = 1'b0;
        req_rdy_c    = 1'b0;
        if (rst && (state_q == IDLE)) begin
            rsp_rdy_c = bus.l2_rsp_out_valid & ~(bus.l2_req_out_valid & starve_sat_c);
            req_rdy_c = bus.l2_req_out_valid & ~rsp_rdy_c;
        end
        grant_c = rsp_rdy_c | req_rdy_c;
        fire_c  = valid_q & bus.noc_out_ready;
    end

    assign bus.l2_req_out_ready = req_rdy_c;
    assign bus.l2_rsp_out_ready = rsp_rdy_c;
    assign bus.noc_out_valid    = valid_q;
    assign bus.noc_out_data     = data_q;

    // Select the granted message and build its HDR0 flit.
    always_comb begin
        if (rsp_rdy_c) begin
            sel_plane_c = PLANE_RSP;
            sel_msg_c   = bus.l2_rsp_out.coh_msg;
            sel_addr_c  = bus.l2_rsp_out.addr;
            sel_line_c  = bus.l2_rsp_out.line;
            sel_mask_c  = bus.l2_rsp_out.word_mask;
            sel_dst_c   = bus.l2_rsp_out.to_req ? bus.l2_rsp_out.req_id
                                                : NOC_ID_W'(bus.l2_rsp_out.addr[HOME_BITS-1:0]);
        end else begin
            sel_plane_c = PLANE_REQ;
            sel_msg_c   = bus.l2_req_out.coh_msg;
            sel_addr_c  = bus.l2_req_out.addr;
            sel_line_c  = bus.l2_req_out.line;
            sel_mask_c  = bus.l2_req_out.word_mask;
            sel_dst_c   = NOC_ID_W'(bus.l2_req_out.addr[HOME_BITS-1:0]);
        end

        hdr0_c                                = '0;
        hdr0_c[FLIT_HEAD_BIT]                 = 1'b1;
        hdr0_c[HDR_MSG_LSB +: HDR_MSG_W]      = HDR_MSG_W'(sel_msg_c);
        hdr0_c[HDR_DST_LSB +: NOC_ID_W]       = sel_dst_c;
        hdr0_c[HDR_SRC_LSB +: NOC_ID_W]       = SRC_ID;
        hdr0_c[HDR_PLANE_BIT]                 = sel_plane_c;
        hdr0_c[HDR_MASK_LSB +: HDR_MASK_W]    = HDR_MASK_W'(sel_mask_c);
    end

    // Packet FSM: capture in IDLE, then HDR0 -> HDR1 -> DATA*, advancing only on a flit handshake.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        addr_d   = addr_q;
        line_d   = line_q;
        rem_d    = rem_q;
        starve_d = starve_q;

        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d = HDR0;
                    valid_d = 1'b1;
                    data_d  = hdr0_c;
                    addr_d  = sel_addr_c;
                    line_d  = sel_line_c;
                    // Data-less messages still advertise their mask in HDR0 but send no words.
                    rem_d   = msg_has_data(sel_plane_c, sel_msg_c) ? sel_mask_c : '0;
                    if (req_rdy_c || !bus.l2_req_out_valid) begin
                        starve_d = '0;
                    end else if (!starve_sat_c) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            HDR0: begin
                if (fire_c) begin
                    state_d                = HDR1;
                    data_d                 = '0;
                    data_d[FLIT_TAIL_BIT]  = (rem_q == '0);
                    data_d[NOC_PAYLOAD_W-1:0] = NOC_PAYLOAD_W'(addr_q);
                end
            end
            HDR1, DATA: begin
                if (fire_c) begin
                    if (data_q[FLIT_TAIL_BIT]) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = '0;
                    end else begin
                        state_d = DATA;
                        data_d  = {1'b0, scan_last_c, line_q[scan_idx_c]};
                        rem_d   = rem_q & ~(word_mask_t'(1) << scan_idx_c);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, flit and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            line_q   <= '0;
            rem_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            rem_q    <= rem_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_l2_noc_out_packetizer.sv
// Directed bench for l2_noc_out_packetizer with hand-computed flits.
module tb_l2_noc_out_packetizer;
    import spandex_noc_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_cmp;
    int unsigned n_err;

    l2_noc_out_packetizer_if bus();

    l2_noc_out_packetizer #(
        .SRC_ID     (4'd5),
        .HOME_BITS  (2),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_flit(input string tag, input noc_flit_t exp);
        chk({tag, ".valid"}, 66'(bus.noc_out_valid), 66'(1));
        chk(tag, 66'(bus.noc_out_data), 66'(exp));
        tick();
    endtask

    // Waits (bounded) for the chosen ready, then takes the handshake edge and drops valids.
    task automatic accept(input string tag, input bit is_rsp);
        int waited;
        waited = 0;
        #1;
        while (!(is_rsp ? bus.l2_rsp_out_ready : bus.l2_req_out_ready) && waited < 20) begin
            tick();
            waited++;
        end
        chk(tag, 66'(is_rsp ? bus.l2_rsp_out_ready : bus.l2_req_out_ready), 66'(1));
        tick();
        bus.l2_req_out_valid = 1'b0;
        bus.l2_rsp_out_valid = 1'b0;
    endtask

    function automatic line_t mk_line(input logic [31:0] t);
        line_t l;
        for (int i = 0; i < WORDS_PER_LINE; i++) l[i] = {t, 32'(i)};
        return l;
    endfunction

    function automatic l2_req_out_t mk_req(input coh_msg_t m, input line_addr_t a,
                                           input word_mask_t wm, input line_t l);
        l2_req_out_t r;
        r.coh_msg   = m;
        r.hprot     = 2'b01;
        r.addr      = a;
        r.line      = l;
        r.word_mask = wm;
        return r;
    endfunction

    function automatic l2_rsp_out_t mk_rsp(input coh_msg_t m, input noc_id_t id, input logic to_req,
                                           input line_addr_t a, input word_mask_t wm, input line_t l);
        l2_rsp_out_t r;
        r.coh_msg   = m;
        r.req_id    = id;
        r.to_req    = to_req;
        r.addr      = a;
        r.line      = l;
        r.word_mask = wm;
        return r;
    endfunction

    bit exp_rsp_grant [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int exp_starve    [6] = '{1, 2, 3, 4, 0, 1};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.l2_req_out_valid = 1'b0;
        bus.l2_rsp_out_valid = 1'b0;
        bus.l2_req_out       = '0;
        bus.l2_rsp_out       = '0;
        bus.noc_out_ready    = 1'b1;

        // Reset: outputs cleared, readies held low even with valids up
        tick();
        bus.l2_req_out_valid = 1'b1;
        bus.l2_rsp_out_valid = 1'b1;
        #1;
        chk("reset.valid",   66'(bus.noc_out_valid),    66'(0));
        chk("reset.data",    66'(bus.noc_out_data),     66'(0));
        chk("reset.req_rdy", 66'(bus.l2_req_out_ready), 66'(0));
        chk("reset.rsp_rdy", 66'(bus.l2_rsp_out_ready), 66'(0));
        chk("reset.state",   66'(dut.state_q),          66'(IDLE));
        tick();
        rst = 1'b1;
        bus.l2_req_out_valid = 1'b0;
        bus.l2_rsp_out_valid = 1'b0;
        tick();

        // T1: REQ_S to 0x1040, no data -> HDR0 + HDR1(tail)
        bus.l2_req_out = mk_req(REQ_S, 28'h1040, 4'b0011, mk_line(32'hAAAA_0000));
        bus.l2_req_out_valid = 1'b1;
        accept("t1.req_rdy", 1'b0);
        expect_flit("t1.hdr0", {2'b10, 64'h0050_0003_0000_0000});
        expect_flit("t1.hdr1", {2'b01, 64'h0000_0000_0000_1040});
        chk("t1.idle_valid", 66'(bus.noc_out_valid), 66'(0));

        // T2: RSP_O to requester 3, mask 1010 -> words 1 then 3
        bus.l2_rsp_out = mk_rsp(RSP_O, 4'd3, 1'b1, 28'h2042, 4'b1010, mk_line(32'hB0B0_0000));
        bus.l2_rsp_out_valid = 1'b1;
        accept("t2.rsp_rdy", 1'b1);
        expect_flit("t2.hdr0",  {2'b10, 64'h1358_000A_0000_0000});
        expect_flit("t2.hdr1",  {2'b00, 64'h0000_0000_0000_2042});
        expect_flit("t2.word1", {2'b00, 64'hB0B0_0000_0000_0001});
        expect_flit("t2.word3", {2'b01, 64'hB0B0_0000_0000_0003});
        chk("t2.idle_valid", 66'(bus.noc_out_valid), 66'(0));

        // T3: RSP_S to home 1, mask 0111, backpressure for 5 cycles on word1
        bus.l2_rsp_out = mk_rsp(RSP_S, 4'd9, 1'b0, 28'h3001, 4'b0111, mk_line(32'hC0C0_0000));
        bus.l2_rsp_out_valid = 1'b1;
        accept("t3.rsp_rdy", 1'b1);
        expect_flit("t3.hdr0",  {2'b10, 64'h0158_0007_0000_0000});
        expect_flit("t3.hdr1",  {2'b00, 64'h0000_0000_0000_3001});
        expect_flit("t3.word0", {2'b00, 64'hC0C0_0000_0000_0000});
        bus.noc_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3.hold_valid", 66'(bus.noc_out_valid), 66'(1));
            chk("t3.hold_data",  66'(bus.noc_out_data), {2'b00, 64'hC0C0_0000_0000_0001});
            tick();
        end
        bus.noc_out_ready = 1'b1;
        expect_flit("t3.word1", {2'b00, 64'hC0C0_0000_0000_0001});
        expect_flit("t3.word2", {2'b01, 64'hC0C0_0000_0000_0002});
        chk("t3.idle_valid", 66'(bus.noc_out_valid), 66'(0));

        // T4: both valid every cycle -> rsp x4, req, rsp
        bus.l2_req_out = mk_req(REQ_S, 28'h0005, 4'b0000, mk_line(32'h1111_0000));
        bus.l2_rsp_out = mk_rsp(RSP_INV_ACK, 4'd0, 1'b0, 28'h0002, 4'b0000, mk_line(32'h2222_0000));
        bus.l2_req_out_valid = 1'b1;
        bus.l2_rsp_out_valid = 1'b1;
        for (int p = 0; p < 6; p++) begin
            #1;
            chk("t4.rsp_rdy", 66'(bus.l2_rsp_out_ready), 66'(exp_rsp_grant[p]));
            chk("t4.req_rdy", 66'(bus.l2_req_out_ready), 66'(!exp_rsp_grant[p]));
            tick();
            chk("t4.starve", 66'(dut.starve_q), 66'(exp_starve[p]));
            chk("t4.plane",  66'(bus.noc_out_data[HDR_PLANE_BIT]), 66'(exp_rsp_grant[p]));
            tick();
            chk("t4.hdr1_headtail", 66'(bus.noc_out_data[65:64]), 66'(2'b01));
            tick();
        end
        bus.l2_req_out_valid = 1'b0;
        bus.l2_rsp_out_valid = 1'b0;
        tick();

        // T5: REQ_WB (has data) with mask 0 -> 2 flits, tail on HDR1
        bus.l2_req_out = mk_req(REQ_WB, 28'h0ABC, 4'b0000, mk_line(32'h3333_0000));
        bus.l2_req_out_valid = 1'b1;
        accept("t5.req_rdy", 1'b0);
        expect_flit("t5.hdr0", {2'b10, 64'h4050_0000_0000_0000});
        expect_flit("t5.hdr1", {2'b01, 64'h0000_0000_0000_0ABC});
        chk("t5.idle_valid", 66'(bus.noc_out_valid), 66'(0));
        chk("t5.state",      66'(dut.state_q),       66'(IDLE));

        // T6: reset during HDR1 drops the packet, then a fresh request goes out cleanly
        bus.l2_req_out = mk_req(REQ_O, 28'h0123, 4'b0000, mk_line(32'h4444_0000));
        bus.l2_req_out_valid = 1'b1;
        accept("t6.req_rdy", 1'b0);
        expect_flit("t6.hdr0", {2'b10, 64'h1350_0000_0000_0000});
        chk("t6.hdr1_pre", 66'(bus.noc_out_data), {2'b01, 64'h0000_0000_0000_0123});
        bus.noc_out_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.noc_out_ready = 1'b1;
        chk("t6.rst_valid",   66'(bus.noc_out_valid),    66'(0));
        chk("t6.rst_data",    66'(bus.noc_out_data),     66'(0));
        chk("t6.rst_state",   66'(dut.state_q),          66'(IDLE));
        chk("t6.rst_req_rdy", 66'(bus.l2_req_out_ready), 66'(0));
        chk("t6.rst_rsp_rdy", 66'(bus.l2_rsp_out_ready), 66'(0));
        bus.l2_req_out = mk_req(REQ_WTdata, 28'h0456, 4'b1000, mk_line(32'hD0D0_0000));
        bus.l2_req_out_valid = 1'b1;
        accept("t6.req_rdy2", 1'b0);
        expect_flit("t6.hdr0b", {2'b10, 64'h6250_0008_0000_0000});
        expect_flit("t6.hdr1b", {2'b00, 64'h0000_0000_0000_0456});
        expect_flit("t6.word3", {2'b01, 64'hD0D0_0000_0000_0003});
        chk("t6.idle_valid", 66'(bus.noc_out_valid), 66'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
